// File: rtl/display_field_sel.sv
`default_nettype none
// ============================================================================
// Module      : display_field_sel
// Description : Frame-synchronous field selector feeding the VGA text
//               interface. Chooses date/timer fields by display mode and
//               captures them into a snapshot only at VGA frame boundaries
//               (vsync falling edge) or on force_update.
//               Optional cursor blink mask enabled by macro DISPLAY_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module display_field_sel #(
    parameter int FIELD_W      = 8,
    parameter int NUM_DATE     = 8,
    parameter int NUM_TIMER    = 3,
    parameter int NORMAL_ROT   = 1,
    parameter int CUR_W        = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      vsync,
    input  logic                                      mode_write,
    input  logic                                      mode_crono,
    input  logic                                      mode_cr_activo,
    input  logic                                      freeze,
    input  logic                                      force_update,
    input  logic [(NUM_DATE+NUM_TIMER)*FIELD_W-1:0]   live_fields,
    input  logic [NUM_DATE*FIELD_W-1:0]               edit_fields,
    input  logic [NUM_TIMER*FIELD_W-1:0]              edit_timer,
    input  logic [CUR_W-1:0]                          cursor_idx,
    output logic [(NUM_DATE+NUM_TIMER)*FIELD_W-1:0]   field_out,
    output logic [1:0]                                mode_out,
    output logic                                      frame_tick,
    output logic [NUM_DATE+NUM_TIMER-1:0]             blank_mask
);

    localparam int TOTAL = NUM_DATE + NUM_TIMER;
    // Rotation folded into 0..TOTAL-1 so negative/oversized values still work
    localparam int ROT_MOD = ((NORMAL_ROT % TOTAL) + TOTAL) % TOTAL;

    localparam logic [1:0] MODE_NORMAL    = 2'd0;
    localparam logic [1:0] MODE_WRITE     = 2'd1;
    localparam logic [1:0] MODE_CRONO     = 2'd2;
    localparam logic [1:0] MODE_CR_ACTIVO = 2'd3;

    logic                    r_vs_s1;
    logic                    r_vs_s2;
    logic                    r_vs_d;
    logic                    w_boundary;
    logic                    w_load;
    logic [1:0]              w_mode_sel;
    logic [TOTAL*FIELD_W-1:0] w_sel;

    // Source field index for normal mode: out[i] = live[(i - ROT) mod TOTAL]
    function automatic int norm_src(input int idx);
        return (idx + TOTAL - ROT_MOD) % TOTAL;
    endfunction

    // Mode priority: write > crono > cr_activo > normal
    always_comb begin
        w_mode_sel = MODE_NORMAL;
        if (mode_write)
            w_mode_sel = MODE_WRITE;
        else if (mode_crono)
            w_mode_sel = MODE_CRONO;
        else if (mode_cr_activo)
            w_mode_sel = MODE_CR_ACTIVO;
    end

    // Field selection for the mode that would be captured at this edge
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_DATE; i++) begin
            case (w_mode_sel)
                MODE_WRITE:  w_sel[i*FIELD_W +: FIELD_W] = edit_fields[i*FIELD_W +: FIELD_W];
                MODE_NORMAL: w_sel[i*FIELD_W +: FIELD_W] = live_fields[norm_src(i)*FIELD_W +: FIELD_W];
                default:     w_sel[i*FIELD_W +: FIELD_W] = live_fields[i*FIELD_W +: FIELD_W];
            endcase
        end
        for (int j = 0; j < NUM_TIMER; j++) begin
            case (w_mode_sel)
                MODE_CRONO:     w_sel[(NUM_DATE+j)*FIELD_W +: FIELD_W] = edit_timer[j*FIELD_W +: FIELD_W];
                MODE_CR_ACTIVO: w_sel[(NUM_DATE+j)*FIELD_W +: FIELD_W] = live_fields[(NUM_DATE+j)*FIELD_W +: FIELD_W];
                default:        w_sel[(NUM_DATE+j)*FIELD_W +: FIELD_W] = '0;
            endcase
        end
    end

    // vsync synchroniser plus delay flop for falling-edge detect; idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_s1 <= 1'b1;
            r_vs_s2 <= 1'b1;
            r_vs_d  <= 1'b1;
        end else begin
            r_vs_s1 <= vsync;
            r_vs_s2 <= r_vs_s1;
            r_vs_d  <= r_vs_s2;
        end
    end

    assign w_boundary = r_vs_d & ~r_vs_s2;
    // A boundary suppressed by freeze is simply lost, never queued
    assign w_load     = (w_boundary & ~freeze) | force_update;

    // Snapshot registers: load on frame boundary or forced update, else hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_out  <= '0;
            mode_out   <= MODE_NORMAL;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_load;
            if (w_load) begin
                field_out <= w_sel;
                mode_out  <= w_mode_sel;
            end
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;
    logic             w_blink_mode;
    logic [TOTAL-1:0] w_cursor_mask;

    assign w_blink_mode = (w_mode_sel == MODE_WRITE) | (w_mode_sel == MODE_CRONO);

    // One-hot of the cursor position; out-of-range cursor gives all zeros
    always_comb begin
        w_cursor_mask = '0;
        for (int i = 0; i < TOTAL; i++)
            w_cursor_mask[i] = (cursor_idx == CUR_W'(i));
    end

    // Blink frame counter/phase; mask shows the phase held before this load's advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            blank_mask    <= '0;
        end else if (w_load) begin
            if (w_blink_mode) begin
                blank_mask <= r_blink_phase ? w_cursor_mask : '0;
                if (r_blink_cnt == CNT_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end else begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
                blank_mask    <= '0;
            end
        end
    end
`else
    logic unused_blink;

    assign blank_mask   = '0;
    assign unused_blink = ^{cursor_idx, BLINK_FRAMES[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_display_field_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_field_sel
// Description : Self-checking bench for display_field_sel. A behavioural
//               reference model predicts every output cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_field_sel;

    localparam int FW  = 8;
    localparam int ND  = 8;
    localparam int NT  = 3;
    localparam int TOT = ND + NT;
    localparam int ROT = 1;
    localparam int CW  = 4;
    localparam int BF  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              vsync = 1'b1;
    logic              mode_write = 1'b0;
    logic              mode_crono = 1'b0;
    logic              mode_cr_activo = 1'b0;
    logic              freeze = 1'b0;
    logic              force_update = 1'b0;
    logic [TOT*FW-1:0] live_fields = '0;
    logic [ND*FW-1:0]  edit_fields = '0;
    logic [NT*FW-1:0]  edit_timer = '0;
    logic [CW-1:0]     cursor_idx = '0;
    logic [TOT*FW-1:0] field_out;
    logic [1:0]        mode_out;
    logic              frame_tick;
    logic [TOT-1:0]    blank_mask;

    display_field_sel #(
        .FIELD_W(FW), .NUM_DATE(ND), .NUM_TIMER(NT), .NORMAL_ROT(ROT),
        .CUR_W(CW), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .mode_write(mode_write), .mode_crono(mode_crono),
        .mode_cr_activo(mode_cr_activo), .freeze(freeze),
        .force_update(force_update), .live_fields(live_fields),
        .edit_fields(edit_fields), .edit_timer(edit_timer),
        .cursor_idx(cursor_idx), .field_out(field_out), .mode_out(mode_out),
        .frame_tick(frame_tick), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tick_cnt = 0;

    // Reference model state
    logic           vhist[$];
    logic [FW-1:0]  exp_f[TOT];
    int             exp_mode;
    logic           exp_tick;
    logic [TOT-1:0] exp_mask;
    int             blink_n;

    task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] live_at(input int i);
        return live_fields[i*FW +: FW];
    endfunction

    // What the display should show for field i in mode m
    function automatic logic [FW-1:0] ref_field(input int m, input int i);
        case (m)
            1: return (i < ND) ? edit_fields[i*FW +: FW] : '0;
            2: return (i < ND) ? live_at(i) : edit_timer[(i-ND)*FW +: FW];
            3: return live_at(i);
            default: return (i < ND) ? live_at((((i - ROT) % TOT) + TOT) % TOT) : '0;
        endcase
    endfunction

    function automatic int ref_mode();
        if (mode_write)     return 1;
        if (mode_crono)     return 2;
        if (mode_cr_activo) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        vhist.delete();
        repeat (4) vhist.push_front(1'b1);
        for (int i = 0; i < TOT; i++) exp_f[i] = '0;
        exp_mode = 0;
        exp_tick = 1'b0;
        exp_mask = '0;
        blink_n  = 0;
    endtask

    // Called at each rising edge with the inputs as the DUT sees them
    task automatic model_edge();
        logic boundary, load;
        int   m, ph;
        if (!reset) begin
            model_reset();
            return;
        end
        vhist.push_front(vsync);
        void'(vhist.pop_back());
        // a frame boundary is vsync seen high three edges ago, low two edges ago
        boundary = vhist[3] && !vhist[2];
        load     = (boundary && !freeze) || force_update;
        exp_tick = load;
        if (load) begin
            m = ref_mode();
            for (int i = 0; i < TOT; i++) exp_f[i] = ref_field(m, i);
            exp_mode = m;
`ifdef DISPLAY_BLINK_EN
            if (m == 1 || m == 2) begin
                ph = (blink_n / BF) % 2;
                exp_mask = (ph == 1 && int'(cursor_idx) < TOT) ? (TOT'(1) << cursor_idx) : '0;
                blink_n++;
            end else begin
                blink_n  = 0;
                exp_mask = '0;
            end
`else
            ph = 0;
            exp_mask = '0;
`endif
        end
    endtask

    task automatic check_all(input string pfx);
        logic [TOT*FW-1:0] ev;
        for (int i = 0; i < TOT; i++) ev[i*FW +: FW] = exp_f[i];
        check_value({pfx, "_fields"}, field_out, ev);
        check_value({pfx, "_mode"}, mode_out, exp_mode[1:0]);
        check_value({pfx, "_tick"}, frame_tick, exp_tick);
        check_value({pfx, "_mask"}, blank_mask, exp_mask);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        if (frame_tick) tick_cnt++;
        check_all("cyc");
    endtask

    task automatic frame(input int low_c, input int high_c);
        vsync = 1'b0;
        repeat (low_c) cyc();
        vsync = 1'b1;
        repeat (high_c) cyc();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < TOT; i++) live_fields[i*FW +: FW] = FW'($urandom);
        for (int i = 0; i < ND; i++)  edit_fields[i*FW +: FW] = FW'($urandom);
        for (int i = 0; i < NT; i++)  edit_timer[i*FW +: FW]  = FW'($urandom);
    endtask

    logic [TOT-1:0] exp_blink_seq;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rand_inputs();
        // Reset held, then idle vsync: nothing ever loads
        repeat (3) cyc();
        reset = 1'b1;
        tick_cnt = 0;
        repeat (20) cyc();
        check_value("idle_ticks", tick_cnt, 0);

        // Normal mode with live[i] = 0x10 + i
        for (int i = 0; i < TOT; i++) live_fields[i*FW +: FW] = FW'(8'h10 + i);
        tick_cnt = 0;
        frame(4, 10);
        check_value("norm_ticks", tick_cnt, 1);
        check_value("norm_f0", field_out[0 +: FW], 8'h1A);
        check_value("norm_f1", field_out[FW +: FW], 8'h10);
        check_value("norm_f7", field_out[7*FW +: FW], 8'h16);
        check_value("norm_timer", field_out[ND*FW +: NT*FW], 0);

        // Write and crono raised mid-frame: no change until the boundary
        mode_write = 1'b1;
        mode_crono = 1'b1;
        repeat (5) cyc();
        check_value("wr_hold_mode", mode_out, 2'd0);
        frame(3, 10);
        check_value("wr_mode", mode_out, 2'd1);
        check_value("wr_fields", field_out[ND*FW-1:0], edit_fields);
        check_value("wr_timer", field_out[ND*FW +: NT*FW], 0);

        // Crono with programmed timer values
        mode_write = 1'b0;
        edit_timer = 24'h123005;
        frame(3, 10);
        check_value("cr_t0", field_out[ND*FW +: FW], 8'h05);
        check_value("cr_t1", field_out[(ND+1)*FW +: FW], 8'h30);
        check_value("cr_t2", field_out[(ND+2)*FW +: FW], 8'h12);

        // Freeze: boundaries ignored while live data changes
        freeze = 1'b1;
        tick_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            rand_inputs();
            edit_timer = 24'h123005;
            frame(3, 10);
        end
        check_value("frz_ticks", tick_cnt, 0);
        check_value("frz_t0", field_out[ND*FW +: FW], 8'h05);

        // force_update coincident with a boundary: exactly one tick
        freeze = 1'b0;
        tick_cnt = 0;
        vsync = 1'b0;
        cyc();
        cyc();
        force_update = 1'b1;
        cyc();
        force_update = 1'b0;
        vsync = 1'b1;
        repeat (10) cyc();
        check_value("coin_ticks", tick_cnt, 1);

        // force_update under freeze still loads
        freeze = 1'b1;
        tick_cnt = 0;
        force_update = 1'b1;
        cyc();
        force_update = 1'b0;
        repeat (3) cyc();
        check_value("frz_force_ticks", tick_cnt, 1);
        freeze = 1'b0;

        // Blink: normal load first to clear, then write mode with cursor at 2
        mode_crono = 1'b0;
        frame(3, 8);
        mode_write = 1'b1;
        cursor_idx = 4'd2;
        exp_blink_seq = '0;
        for (int f = 0; f < 10; f++) begin
            frame(3, 8);
`ifdef DISPLAY_BLINK_EN
            check_value("blink_bit", blank_mask[2], ((f / BF) % 2 == 1) ? 1'b1 : 1'b0);
`else
            check_value("blink_bit", blank_mask[2], 1'b0);
`endif
        end
        cursor_idx = 4'd12;
        repeat (6) frame(3, 8);
        check_value("blink_oob", blank_mask, 0);
        cursor_idx = 4'd3;
        repeat (3) frame(3, 8);
        mode_write = 1'b0;
        frame(3, 8);
        check_value("blink_clr", blank_mask, 0);

        // Randomized frames with mid-frame input changes and occasional force
        for (int f = 0; f < 40; f++) begin
            rand_inputs();
            mode_write     = ($urandom_range(0, 3) == 0);
            mode_crono     = $urandom_range(0, 1) == 1;
            mode_cr_activo = $urandom_range(0, 1) == 1;
            freeze         = ($urandom_range(0, 3) == 0);
            cursor_idx     = CW'($urandom_range(0, 15));
            vsync = 1'b0;
            repeat ($urandom_range(2, 5)) cyc();
            vsync = 1'b1;
            for (int c = 0; c < int'($urandom_range(6, 20)); c++) begin
                force_update = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) rand_inputs();
                cyc();
            end
            force_update = 1'b0;
        end

        // Asynchronous reset mid-frame with nonzero outputs and a live tick
        freeze = 1'b0;
        mode_write = 1'b0;
        mode_crono = 1'b0;
        mode_cr_activo = 1'b1;
        cursor_idx = 4'd1;
        for (int i = 0; i < TOT; i++) live_fields[i*FW +: FW] = FW'(8'h21 + i);
        force_update = 1'b1;
        cyc();
        force_update = 1'b0;
        check_value("pre_rst_mode", mode_out, 2'd3);
        #2;
        reset = 1'b0;
        #1;
        check_value("arst_fields", field_out, 0);
        check_value("arst_mode", mode_out, 0);
        check_value("arst_tick", frame_tick, 0);
        check_value("arst_mask", blank_mask, 0);
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
        tick_cnt = 0;
        repeat (15) cyc();
        check_value("post_rst_idle", tick_cnt, 0);
        frame(3, 8);
        check_value("post_rst_ticks", tick_cnt, 1);
        check_value("post_rst_f0", field_out[0 +: FW], 8'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_field_sel.md
# display_field_sel

Frame-synchronous field selector between the RTC state machines and the VGA text interface. It replaces the top-level combinational data mux and generalises it in three ways:
- parametrised field count and width;
- every selection is captured into a registered snapshot at a VGA frame boundary, so a frame never shows mixed old and new values;
- an optional cursor blink mask marks the field being edited.

## Interface
Parameters:
- FIELD_W, 8, bits per field (BCD byte from RTC)
- NUM_DATE, 8, clock/date fields (sec, min, hour, date, month, year, weekday, week number)
- NUM_TIMER, 3, timer fields (sec, min, hour)
- NORMAL_ROT, 1, field rotation applied in normal mode
- CUR_W, 4, cursor index width; 2^CUR_W ≥ NUM_DATE+NUM_TIMER
- BLINK_FRAMES, 30, frames per blink half-period (only with macro)

Ports (TOTAL = NUM_DATE+NUM_TIMER):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vsync (asynchronous to the block's logic, active-low pulse)
- mode_write  in  1  write/edit clock mode
- mode_crono  in  1  timer programming mode
- mode_cr_activo  in  1  timer running mode
- freeze  in  1  ignore frame boundaries
- force_update  in  1  load snapshot on next edge regardless of vsync
- live_fields  in  TOTAL*FIELD_W  fields read from RTC, field i at [i*FIELD_W +: FIELD_W]
- edit_fields  in  NUM_DATE*FIELD_W  date values being edited
- edit_timer  in  NUM_TIMER*FIELD_W  timer values being programmed
- cursor_idx  in  CUR_W  field under edit cursor
- field_out  out  TOTAL*FIELD_W  snapshot to VGA interface
- mode_out  out  2  snapshot mode: 0 normal, 1 write, 2 crono, 3 cr_activo
- frame_tick  out  1  one-cycle pulse on every snapshot load
- blank_mask  out  TOTAL  1 = VGA blanks that field

## Operation
- Mode priority is mode_write > mode_crono > mode_cr_activo > normal.
- Selection per mode:
  - write: out[i]=edit_fields[i] for i<NUM_DATE; timer outputs 0.
  - crono: date outputs = live[i]; timer outputs = edit_timer.
  - cr_activo: out[i]=live[i] for all i.
  - normal: out[i]=live[(i−NORMAL_ROT) mod TOTAL] for i<NUM_DATE; timer outputs 0. With the defaults, out[0]=live[10] and out[1]=live[0].
- vsync passes through a 2-flop synchroniser, then falling-edge detection. A detected fall is a frame boundary.
- Load event:
  - (frame boundary AND NOT freeze) OR force_update.
  - On a load: field_out, mode_out ← selection; frame_tick=1 in the same cycle outputs change.
- Between loads, outputs hold regardless of input or mode changes.
- force_update coinciding with a frame boundary produces one load and one tick.
- force_update while freeze=1 still loads.
- A boundary missed during freeze is not replayed when freeze drops.

## Timing
- Reset (reset=0, asynchronous):
  - field_out=0, mode_out=0, frame_tick=0, blank_mask=0.
  - Synchroniser flops =1 (vsync idle), so release never creates a false edge.
  - Blink counter and phase =0.
- vsync fall to field_out update: 3 clk edges (2 sync + 1 edge-detect/load).
- force_update sampled high at edge N: outputs valid and frame_tick high after edge N.
- Inputs are sampled only on the load edge, with no setup requirement beyond the clock.
- vsync pulses shorter than 2 clk periods may be lost; VGA vsync spans thousands of clocks.

## Configuration
- DISPLAY_BLINK_EN defined:
  - A frame counter 0..BLINK_FRAMES−1 advances on each load event while the newly loaded mode is write or crono.
  - On wrap the counter returns to 0 and the blink phase toggles.
  - blank_mask[cursor_idx]=phase. All mask bits are 0 if cursor_idx ≥ TOTAL or mode_out is normal/cr_activo.
  - A load into normal/cr_activo clears the counter and phase.
  - blank_mask is registered and updates on the load edge.
- DISPLAY_BLINK_EN undefined: blank_mask is tied to 0, and no counter or phase logic is generated.

## Test plan
Bench parameters: defaults, BLINK_FRAMES=4.
- Reset, then hold vsync high with no force: field_out=0, mode_out=0, frame_tick never pulses, including across reset release.
- Normal mode: live[i]=0x10+i, vsync fall → 3 edges later field_out[0]=0x1A, field_out[1]=0x10, field_out[7]=0x16, timer outputs 0, one frame_tick.
- mode_write and mode_crono both high mid-frame: mode_out stays 0 until next boundary, then becomes 1; field_out[i]=edit_fields[i].
- Crono mode with edit_timer={0x05,0x30,0x12}: outputs 8..10 = 0x05,0x30,0x12 after boundary. Then freeze=1: changing live_fields across 3 vsyncs leaves field_out unchanged. Then force_update=1 with a coincident boundary: exactly one tick.
- DISPLAY_BLINK_EN, write mode, cursor_idx=2: blank_mask[2] toggles every 4 frames (0,0,0,0,1,1,1,1,0...). cursor_idx=12 gives mask 0. Switching to normal clears mask at that load.
- Assert reset mid-frame with outputs nonzero: all outputs 0 immediately, without waiting for clk. After release, first load only at next real vsync fall.
